// File: rtl/fine_delay_tap_ctrl.sv
// Tap controller for an IODELAY2 fine-delay element.
// On reset it calibrates and then resets the tap. In IDLE it accepts a target
// tap, or a recalibration request. A move to a target is made one tap at a time,
// and every IODELAY2 command waits for BUSY to clear. If BUSY stays high too long,
// the controller locks into ERR until the next reset.
module fine_delay_tap_ctrl #(
    parameter int unsigned TAP_W   = 8,
    parameter int unsigned MAX_TAP = 255,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             m_clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TAP_W-1:0] target_tap,
    input  logic             recal,
    input  logic             iod_busy,
    output logic             iod_cal,
    output logic             iod_rst,
    output logic             iod_ce,
    output logic             iod_inc,
    output logic [TAP_W-1:0] cur_tap,
    output logic             ready,
    output logic             done,
    output logic             err
);

    localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [TAP_W-1:0] MAX_TAP_V = TAP_W'(MAX_TAP);
    localparam logic [CNT_W-1:0] TMO_V     = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        CAL, CAL_WAIT, TRST, TRST_WAIT, IDLE, STEP, STEP_WAIT, ERR
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic [TAP_W-1:0] tgt, tgt_d, tap_d, load_tgt;
    logic             cal_d, trst_d, ce_d, inc_d, ready_d, done_d, err_d;
    logic             in_wait, guard, wait_exit, wait_tmo;

    // Wait-state qualifiers. The first wait cycle is a guard cycle, so BUSY is
    // only trusted after the primitive has had a cycle to raise it.
    always_comb begin
        in_wait   = (state == CAL_WAIT) || (state == TRST_WAIT) || (state == STEP_WAIT);
        guard     = (wait_cnt == '0);
        wait_exit = in_wait && !guard && !iod_busy;
        wait_tmo  = in_wait && !guard && iod_busy && (wait_cnt >= TMO_V);
        load_tgt  = (target_tap > MAX_TAP_V) ? MAX_TAP_V : target_tap;
    end

    // State register.
    always_ff @(posedge m_clk) begin
        if (rst) state <= CAL;
        else     state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            CAL:       next_state = CAL_WAIT;
            CAL_WAIT:  if (wait_tmo) next_state = ERR; else if (wait_exit) next_state = TRST;
            TRST:      next_state = TRST_WAIT;
            TRST_WAIT: if (wait_tmo) next_state = ERR; else if (wait_exit) next_state = IDLE;
            IDLE: begin
                if (recal)                             next_state = CAL;
                else if (load && (load_tgt != cur_tap)) next_state = STEP;
            end
            STEP:      next_state = STEP_WAIT;
            STEP_WAIT: begin
                if (wait_tmo)       next_state = ERR;
                else if (wait_exit) next_state = (cur_tap == tgt) ? IDLE : STEP;
            end
            ERR:       next_state = ERR;
            default:   next_state = CAL;
        endcase
    end

    // Next values of the registered outputs and datapath. Each command pulse is
    // decoded from the current state, so it appears in the cycle after the state.
    // The tap moves on the same edge that raises CE.
    always_comb begin
        cal_d      = (state == CAL);
        trst_d     = (state == TRST);
        ce_d       = (state == STEP);
        inc_d      = iod_inc;
        tap_d      = cur_tap;
        tgt_d      = tgt;
        ready_d    = (next_state == IDLE);
        err_d      = err || (next_state == ERR);
        done_d     = 1'b0;
        wait_cnt_d = (in_wait && (next_state == state)) ? wait_cnt + 1'b1 : '0;
        if (state == STEP) begin
            inc_d = (tgt > cur_tap);
            if (tgt > cur_tap)      tap_d = cur_tap + 1'b1;
            else if (tgt < cur_tap) tap_d = cur_tap - 1'b1;
        end
        if ((state == TRST_WAIT) && (next_state == IDLE)) tap_d = '0;
        if ((state == STEP_WAIT) && (next_state == IDLE)) done_d = 1'b1;
        if ((state == IDLE) && !recal && load) begin
            tgt_d = load_tgt;
            if (load_tgt == cur_tap) done_d = 1'b1;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge m_clk) begin
        if (rst) begin
            iod_cal  <= 1'b0;
            iod_rst  <= 1'b0;
            iod_ce   <= 1'b0;
            iod_inc  <= 1'b0;
            cur_tap  <= '0;
            tgt      <= '0;
            ready    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            iod_cal  <= cal_d;
            iod_rst  <= trst_d;
            iod_ce   <= ce_d;
            iod_inc  <= inc_d;
            cur_tap  <= tap_d;
            tgt      <= tgt_d;
            ready    <= ready_d;
            done     <= done_d;
            err      <= err_d;
            wait_cnt <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_fine_delay_tap_ctrl.sv
// Self-checking bench for fine_delay_tap_ctrl. A procedural reference model
// predicts every output on every cycle. Directed scenarios then pin down the
// model with literal values, and a randomized phase follows them.
module tb_fine_delay_tap_ctrl;

    localparam int TAP_W   = 8;
    localparam int MAX_TAP = 200;
    localparam int TIMEOUT = 20;

    logic             m_clk = 1'b0;
    logic             rst = 1'b1, load = 1'b0, recal = 1'b0, iod_busy = 1'b0;
    logic [TAP_W-1:0] target_tap = '0;
    logic             iod_cal, iod_rst, iod_ce, iod_inc, ready, done, err;
    logic [TAP_W-1:0] cur_tap;

    fine_delay_tap_ctrl #(.TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .TIMEOUT(TIMEOUT)) dut (
        .m_clk(m_clk), .rst(rst), .load(load), .target_tap(target_tap), .recal(recal),
        .iod_busy(iod_busy), .iod_cal(iod_cal), .iod_rst(iod_rst), .iod_ce(iod_ce),
        .iod_inc(iod_inc), .cur_tap(cur_tap), .ready(ready), .done(done), .err(err)
    );

    always #5 m_clk = ~m_clk;

    int vectors = 0, miscompares = 0;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    bit m_cal, m_rst, m_ce, m_inc, m_ready, m_done, m_err;
    int m_tap;

    function automatic void model_reset();
        m_cal = 0; m_rst = 0; m_ce = 0; m_inc = 0; m_ready = 0; m_done = 0; m_err = 0; m_tap = 0;
    endfunction

    task automatic edge_();
        @(posedge m_clk);
        m_cal = 0; m_rst = 0; m_ce = 0; m_done = 0;
    endtask

    // Wait for the command to finish. One guard cycle comes first. After that,
    // BUSY=0 ends the wait, and TIMEOUT busy cycles make it fail.
    task automatic settle(output bit ok);
        int k;
        edge_();
        k = 1;
        forever begin
            edge_();
            if (!iod_busy) begin ok = 1; return; end
            if (k >= TIMEOUT) begin ok = 0; return; end
            k++;
        end
    endtask

    task automatic hang_err();
        m_err = 1; m_ready = 0;
        forever edge_();
    endtask

    // Entered on the edge where the controller starts calibration.
    task automatic run_seq();
        bit ok;
        int t;
        forever begin
            m_cal = 1; m_ready = 0;
            settle(ok); if (!ok) hang_err();
            edge_(); m_rst = 1;
            settle(ok); if (!ok) hang_err();
            m_tap = 0; m_ready = 1;
            forever begin
                edge_();
                if (recal) begin m_ready = 0; break; end
                if (load) begin
                    t = (int'(target_tap) > MAX_TAP) ? MAX_TAP : int'(target_tap);
                    if (t == m_tap) m_done = 1;
                    else begin
                        m_ready = 0;
                        while (m_tap != t) begin
                            edge_();
                            m_ce = 1; m_inc = (t > m_tap);
                            m_tap = m_tap + (m_inc ? 1 : -1);
                            settle(ok); if (!ok) hang_err();
                        end
                        m_ready = 1; m_done = 1;
                    end
                end
            end
            edge_();
        end
    endtask

    // Model supervisor: any edge with rst asserted restarts the sequence.
    initial begin
        model_reset();
        forever begin
            do @(posedge m_clk); while (rst);
            fork
                run_seq();
                begin do @(posedge m_clk); while (!rst); end
            join_any
            disable fork;
            model_reset();
        end
    end

    // ---------------- IODELAY2 busy model ----------------
    int busy_cnt = 0, busy_len = 10;
    bit busy_stuck = 0, busy_rand = 0;

    // Raise BUSY for a while after each command pulse.
    always @(negedge m_clk) begin
        if (busy_cnt > 0) busy_cnt--;
        if (iod_cal || iod_rst || iod_ce)
            busy_cnt = busy_rand ? int'($urandom_range(0, 4)) : busy_len;
        iod_busy = busy_stuck || (busy_cnt > 0);
    end

    // ---------------- per-cycle compare and event monitors ----------------
    int cyc = 0, ce_cnt, inc1_cnt, inc0_cnt, gap_bad, last_ce, cal_cnt, rst_cnt, done_cnt;
    int cal_cyc, rstp_cyc;

    task automatic reset_counters();
        ce_cnt = 0; inc1_cnt = 0; inc0_cnt = 0; gap_bad = 0; last_ce = -1;
        cal_cnt = 0; rst_cnt = 0; done_cnt = 0; cal_cyc = -1; rstp_cyc = -1;
    endtask

    // Compare every output with the model and log command events.
    always @(negedge m_clk) begin
        cyc++;
        check("iod_cal", iod_cal, m_cal);
        check("iod_rst", iod_rst, m_rst);
        check("iod_ce", iod_ce, m_ce);
        check("iod_inc", iod_inc, m_inc);
        check("cur_tap", cur_tap, m_tap);
        check("ready", ready, m_ready);
        check("done", done, m_done);
        check("err", err, m_err);
        if (iod_ce) begin
            ce_cnt++;
            if (iod_inc) inc1_cnt++; else inc0_cnt++;
            if (last_ce >= 0 && cyc - last_ce != 3) gap_bad++;
            last_ce = cyc;
        end
        if (iod_cal) begin cal_cnt++; cal_cyc = cyc; end
        if (iod_rst) begin rst_cnt++; rstp_cyc = cyc; end
        if (done) done_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc_wait();
        @(negedge m_clk); #1;
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (!ready && n < limit) begin cyc_wait(); n++; end
        check("ready_within_bound", ready, 1);
    endtask

    task automatic do_load(input int t);
        load = 1; target_tap = TAP_W'(t);
        cyc_wait();
        load = 0; target_tap = TAP_W'($urandom);
    endtask

    initial begin
        reset_counters();
        repeat (3) cyc_wait();
        check("rst_cur_tap", cur_tap, 0);
        check("rst_ready", ready, 0);
        check("rst_err", err, 0);
        check("rst_iod_cal", iod_cal, 0);

        // Reset release with a 10-cycle busy after each command.
        reset_counters(); rst = 0;
        wait_ready(300);
        check("init_cal_pulses", cal_cnt, 1);
        check("init_rst_pulses", rst_cnt, 1);
        check("init_cal_before_rst", int'(cal_cyc < rstp_cyc), 1);
        check("init_cur_tap", cur_tap, 0);
        check("init_err", err, 0);

        // Move 0 -> 5 with BUSY low. The target bus changes after the load.
        busy_len = 0; reset_counters();
        do_load(5); wait_ready(100);
        check("up5_cur_tap", cur_tap, 5);
        check("up5_ce_pulses", ce_cnt, 5);
        check("up5_inc_high", inc1_cnt, 5);
        check("up5_gap3", gap_bad, 0);
        check("up5_done_pulses", done_cnt, 1);

        // Move 5 -> 2, then load the same tap again.
        reset_counters();
        do_load(2); wait_ready(100);
        check("dn2_cur_tap", cur_tap, 2);
        check("dn2_ce_pulses", ce_cnt, 3);
        check("dn2_inc_low", inc0_cnt, 3);
        reset_counters();
        do_load(2);
        check("same_done_next", done, 1);
        check("same_ready", ready, 1);
        repeat (4) cyc_wait();
        check("same_no_ce", ce_cnt, 0);
        check("same_done_pulses", done_cnt, 1);

        // Load 255 clamps to 200. Load and recal during the move are ignored.
        reset_counters();
        do_load(255); repeat (10) cyc_wait();
        load = 1; target_tap = 3; cyc_wait(); load = 0;
        repeat (7) cyc_wait();
        recal = 1; cyc_wait(); recal = 0;
        wait_ready(1000);
        check("clamp_cur_tap", cur_tap, 200);
        check("clamp_ce_pulses", ce_cnt, 198);
        check("clamp_no_cal", cal_cnt, 0);
        reset_counters();
        do_load(250);
        check("clamp_same_done", done, 1);
        repeat (4) cyc_wait();
        check("clamp_same_no_ce", ce_cnt, 0);

        // recal and load in the same cycle: recal wins.
        busy_len = 3; reset_counters();
        recal = 1; load = 1; target_tap = 10; cyc_wait(); recal = 0; load = 0;
        wait_ready(200);
        check("recal_cur_tap", cur_tap, 0);
        check("recal_no_ce", ce_cnt, 0);
        check("recal_cal_pulses", cal_cnt, 1);
        check("recal_no_done", done_cnt, 0);

        // BUSY stuck high during a move causes a timeout error. Only rst recovers.
        busy_len = 0; reset_counters();
        do_load(50); repeat (2) cyc_wait();
        busy_stuck = 1;
        begin
            int n = 0;
            while (!err && n < TIMEOUT + 30) begin cyc_wait(); n++; end
        end
        check("tmo_err", err, 1);
        check("tmo_ready", ready, 0);
        reset_counters();
        repeat (10) cyc_wait();
        check("err_no_pulses", ce_cnt + cal_cnt + rst_cnt, 0);
        check("err_sticky", err, 1);
        rst = 1; busy_stuck = 0; cyc_wait(); cyc_wait();
        check("err_rst_err", err, 0);
        check("err_rst_tap", cur_tap, 0);
        reset_counters(); rst = 0; busy_len = 5;
        wait_ready(200);
        check("err_recal_cal", cal_cnt, 1);
        check("err_recal_rst", rst_cnt, 1);

        // Randomized phase: sporadic commands, random busy, occasional reset.
        busy_rand = 1;
        repeat (8000) begin
            load       = ($urandom_range(0, 19) == 0);
            recal      = ($urandom_range(0, 299) == 0);
            target_tap = TAP_W'($urandom);
            rst        = ($urandom_range(0, 2999) == 0);
            cyc_wait();
        end
        rst = 0; load = 0; recal = 0;
        repeat (20) cyc_wait();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
